strobe_ram_ctrl: RTL

- Parametrised single-port RAM controller. Write and read commands are qualified by a slow, asynchronous strobe (`strobe`), which is synchronised and rising-edge detected in the `clk` domain.
- Successor to the fixed 8-entry strobe RAM. Adds parametrised width and depth, a read-valid pulse, write-over-read priority, and a hardware clear sequencer with a busy flag.
- Sits between a slow host or bit-bang interface and local storage.

---
 rtl/strobe_ram_pkg.sv | 15 +
 rtl/strobe_edge_sync.sv | 27 ++
 rtl/strobe_ram_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/strobe_ram_pkg.sv
// Shared types and helpers for the strobe-qualified RAM controller.
// Parity support in strobe_ram_ctrl is enabled with `define STROBE_RAM_PARITY_EN.
package strobe_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Even parity; callers zero-extend narrower words, which leaves the result unchanged.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/strobe_edge_sync.sv
// Three-flop synchroniser for the asynchronous command strobe with rising-edge detect.
// A strobe already high when reset releases still yields one edge.
module strobe_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    output logic stb_edge_o
);

    logic s1_q, s2_q, s3_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= strobe_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign stb_edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/strobe_ram_ctrl.sv
// Single-port RAM controller driven by a slow asynchronous strobe, with a hardware clear sequencer.
// Define STROBE_RAM_PARITY_EN to store and check an even-parity bit per word.
module strobe_ram_ctrl
    import strobe_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              par_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef STROBE_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic stb_edge;

    strobe_edge_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .strobe_i   (strobe),
        .stb_edge_o (stb_edge)
    );

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rd_valid_q, rd_valid_d;
    logic               par_err_q, par_err_d;

    logic [MEM_W-1:0]   mem_q [DEPTH];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [MEM_W-1:0]   mem_wdata;
    logic [MEM_W-1:0]   rd_word;

    assign rd_word = mem_q[addr];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        par_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr;
`ifdef STROBE_RAM_PARITY_EN
        mem_wdata  = {even_parity(64'(wdata)), wdata};
`else
        mem_wdata  = wdata;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (stb_edge) begin
                    if (wr_en) begin
                        mem_we = 1'b1;
                    end else if (rd_en) begin
                        rdata_d    = rd_word[DATA_W-1:0];
                        rd_valid_d = 1'b1;
`ifdef STROBE_RAM_PARITY_EN
                        par_err_d  = even_parity(64'(rd_word[DATA_W-1:0])) != rd_word[DATA_W];
`endif
                    end
                end
                // A command on the same edge still executes; the clear starts alongside it.
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            par_err_q  <= par_err_d;
        end
    end

    // NOTE: the array has no reset; contents are defined only by writes or the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign par_err  = par_err_q;

endmodule
